// File: rtl/stream_bus_demux.sv
// stream_bus_demux
//   Steers each word of one valid/ready input stream to one of NUM_CH output
//   channels chosen per word by SEL. Every channel has its own DEPTH-entry
//   circular FIFO, so a stalled consumer only blocks its own channel.
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   RST_N      asynchronous active-low reset; empties every FIFO
//   Y          input data word
//   Y_VALID    input word present
//   Y_READY    the channel addressed by SEL can take the word (combinational)
//   SEL        destination channel for Y
//   OUT_DATA   channel i head word at [i*BUS_WIDTH +: BUS_WIDTH]
//   OUT_VALID  bit i set while channel i FIFO is non-empty
//   OUT_READY  bit i: consumer i takes the head word
//   SEL_ERR    sticky flag, a word with an out-of-range SEL was dropped
//   ERR_CLR    synchronous clear of SEL_ERR (a same-cycle drop wins)
module stream_bus_demux #(
  parameter  int BUS_WIDTH = 8,
  parameter  int NUM_CH    = 4,
  parameter  int DEPTH     = 4,
  localparam int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [BUS_WIDTH-1:0]        Y,
  input  logic                        Y_VALID,
  output logic                        Y_READY,
  input  logic [SEL_W-1:0]            SEL,
  output logic [NUM_CH*BUS_WIDTH-1:0] OUT_DATA,
  output logic [NUM_CH-1:0]           OUT_VALID,
  input  logic [NUM_CH-1:0]           OUT_READY,
  output logic                        SEL_ERR,
  input  logic                        ERR_CLR
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [BUS_WIDTH-1:0] mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]     wr_ptr [NUM_CH];
  logic [PTR_W-1:0]     rd_ptr [NUM_CH];
  logic [CNT_W-1:0]     count  [NUM_CH];

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic              sel_ok;
  logic              ready_sel;
  logic              drop;

  // Decode SEL against every channel index instead of indexing count[SEL],
  // so an out-of-range SEL (non power-of-2 NUM_CH) never indexes past the
  // arrays and simply reads as "ready, no channel".
  always_comb begin
    sel_ok    = 1'b0;
    ready_sel = 1'b1;
    push      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (SEL == SEL_W'(i)) begin
        sel_ok    = 1'b1;
        ready_sel = (count[i] != FULL_CNT);
        push[i]   = Y_VALID && (count[i] != FULL_CNT);
      end
    end
  end

  assign Y_READY = ready_sel;
  assign drop    = Y_VALID && !sel_ok;

  always_comb begin
    pop       = '0;
    OUT_VALID = '0;
    OUT_DATA  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      OUT_VALID[i] = (count[i] != '0);
      pop[i]       = OUT_READY[i] && (count[i] != '0);
      OUT_DATA[i*BUS_WIDTH +: BUS_WIDTH] = mem[i][rd_ptr[i]];
    end
  end

  // DEPTH is a power of 2, so pointer wrap from DEPTH-1 to 0 is the natural
  // PTR_W-bit rollover.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem[i][j] <= '0;
        end
      end
      SEL_ERR <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= Y;
          wr_ptr[i]         <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
      if (drop) begin
        SEL_ERR <= 1'b1;
      end else if (ERR_CLR) begin
        SEL_ERR <= 1'b0;
      end
    end
  end

endmodule
